seq_gen: RTL
============

# seq_gen

Serial sequence generator: the transmit end of the single-bit serial link consumed by the sequence detector. Accepts W-bit parallel words over a valid/ready handshake and emits each one as a framed serial stream, one bit per CLK: the SYNC_W-bit sync pattern first, then the data MSB-first, then GAP idle cycles. Output bits are registered and change only on the rising CLK edge, so the detector's rising-edge sampler can be driven directly. Also used as the stimulus source in detector benches in place of file-driven patterns.

## Interface
- W, 8, data word width (>= 1)
- SYNC_W, 4, sync pattern width (>= 1)
- SYNC, 4'b1011, sync pattern, transmitted MSB-first
- GAP, 2, idle cycles after each frame (>= 0)
- CNT_W, 16, FRAME_CNT width
- CLK  in  1  clock, all state changes on the rising edge
- RST  in  1  reset, asynchronous, active-low
- DIN  in  W  parallel data word, sampled only on accept
- LOAD  in  1  word valid
- READY  out  1  generator can accept a word this cycle
- D_OUT  out  1  serial bit to the detector's D_IN
- D_VLD  out  1  D_OUT carries a frame bit (sync or data)
- BUSY  out  1  state != IDLE
- FRAME_DONE  out  1  high during the last data bit of a frame
- FRAME_CNT  out  CNT_W  count of completed frames, wraps modulo 2^CNT_W

## Operation
- States: IDLE, SYNC, DATA, GAP. The state register, bit counter, shift register and all outputs are registered.
- Accept = LOAD && READY at a rising edge. On accept, DIN is copied into the shift register and the bit counter is loaded.
- LOAD while READY=0 is ignored. DIN is never re-sampled during a frame.
- IDLE:
  - READY=1, D_OUT=0, D_VLD=0.
  - Accept → SYNC.
- SYNC: SYNC_W cycles. D_OUT = SYNC[SYNC_W-1] down to SYNC[0], D_VLD=1. Then → DATA.
- DATA: W cycles. D_OUT = word[W-1] down to word[0], D_VLD=1.
  - FRAME_DONE=1 in the cycle carrying word[0].
  - FRAME_CNT increments at the rising edge that ends that cycle.
  - Exit: → GAP if GAP>0; otherwise → SYNC on accept, else → IDLE.
- GAP: GAP cycles. D_OUT=0, D_VLD=0.
  - After the last GAP cycle: → SYNC if accept, else → IDLE.
- READY=1 in:
  - IDLE;
  - the final GAP cycle;
  - the word[0] DATA cycle when GAP=0.
  - READY=0 everywhere else.
- Back-to-back: a word accepted in the final READY cycle starts SYNC on the next cycle, with no extra idle cycle.
- FRAME_CNT wraps from 2^CNT_W-1 to 0 without saturating.
- Reset (RST=0, any time, including mid-frame):
  - Immediately: state=IDLE, D_OUT=0, D_VLD=0, FRAME_DONE=0, BUSY=0, FRAME_CNT=0, shift register cleared.
  - READY=1 as soon as the state is IDLE.
  - The partial frame is dropped and not resumed.
- Reset release: first accept possible at the first rising edge with RST=1.

## Timing
- Accept at edge t0 → the first sync bit is on D_OUT after t0. The data MSB appears after edge t0+SYNC_W.
- FRAME_DONE is high for the interval between edges t0+SYNC_W+W-1 and t0+SYNC_W+W.
- A frame occupies SYNC_W+W+GAP cycles. Sustained throughput is 1 word per SYNC_W+W+GAP cycles.
- With GAP=0, D_VLD stays high continuously across back-to-back frames.
- Outputs are stable for a full cycle after each rising edge. The downstream detector samples on the next rising edge, giving one cycle of latency per bit.

## Test plan
- Default params, reset 4 cycles, LOAD=1 with DIN=8'hA5 in IDLE:
  - D_OUT = 1,0,1,1, 1,0,1,0,0,1,0,1 with D_VLD=1.
  - FRAME_DONE only on the 12th bit.
  - Then 2 cycles of D_OUT=0/D_VLD=0.
  - FRAME_CNT=1; READY high again on the 2nd GAP cycle.
- Back-to-back, LOAD held high with 8'hFF then 8'h00:
  - Second SYNC starts on the cycle right after the final GAP cycle.
  - FRAME_CNT=2; exactly 28 cycles from the first accept to the end of the second GAP.
- GAP=0, three words 8'h01, 8'h80, 8'h3C:
  - D_VLD high for 36 consecutive cycles.
  - FRAME_DONE pulses at bits 12, 24 and 36.
- LOAD pulsed with 8'h55 during SYNC and DATA of an 8'hA5 frame:
  - Pulses ignored; only the 8'hA5 bits are transmitted.
  - FRAME_CNT advances by 1.
- RST pulled low during DATA bit 3, then released:
  - All outputs 0 immediately, READY=1, FRAME_CNT=0.
  - A new accept of 8'hC3 gives a clean 12-bit frame.
- CNT_W=2, five frames → FRAME_CNT sequence 1,2,3,0,1.

Source files
------------

// File: rtl/seq_gen.sv
// Framed serial transmitter: each accepted word goes out as SYNC pattern, then data MSB-first,
// then GAP idle cycles, one registered bit per CLK.
module seq_gen #(
  parameter int                W      = 8,
  parameter int                SYNC_W = 4,
  parameter logic [SYNC_W-1:0] SYNC   = 4'b1011,
  parameter int                GAP    = 2,
  parameter int                CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [W-1:0]     DIN,
  input  logic             LOAD,
  output logic             READY,
  output logic             D_OUT,
  output logic             D_VLD,
  output logic             BUSY,
  output logic             FRAME_DONE,
  output logic [CNT_W-1:0] FRAME_CNT
);

  localparam int FW   = SYNC_W + W;
  localparam int MAXC = (W > SYNC_W) ? ((W > GAP) ? W : GAP) : ((SYNC_W > GAP) ? SYNC_W : GAP);
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  logic [1:0]       state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [FW-1:0]    sh, sh_n;
  logic             dout_n, dvld_n, fdone_n, ready_n, start, accept;
  logic [CNT_W-1:0] fcnt_n;

  assign accept = LOAD && READY;

  // Sync pattern and data share one shift register; cnt counts cycles left in the current phase.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    dout_n  = 1'b0;
    dvld_n  = 1'b0;
    fdone_n = 1'b0;
    ready_n = 1'b0;
    fcnt_n  = FRAME_CNT;
    start   = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_n = 1'b1;
        start   = accept;
      end
      ST_SYNC: begin
        dout_n = sh[FW-1];
        dvld_n = 1'b1;
        sh_n   = sh << 1;
        if (cnt == '0) begin
          state_n = ST_DATA;
          cnt_n   = CW'(W - 1);
          fdone_n = (W == 1);
          ready_n = (W == 1) && (GAP == 0);
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt == '0) begin
          fcnt_n = FRAME_CNT + 1'b1;
          if (GAP > 0) begin
            state_n = ST_GAP;
            cnt_n   = CW'(GAP - 1);
            ready_n = (GAP == 1);
          end else begin
            state_n = ST_IDLE;
            ready_n = 1'b1;
            start   = accept;
          end
        end else begin
          dout_n = sh[FW-1];
          dvld_n = 1'b1;
          sh_n   = sh << 1;
          cnt_n  = cnt - 1'b1;
          if (cnt == CW'(1)) begin
            fdone_n = 1'b1;
            ready_n = (GAP == 0);
          end
        end
      end
      default: begin
        if (cnt == '0) begin
          state_n = ST_IDLE;
          ready_n = 1'b1;
          start   = accept;
        end else begin
          cnt_n   = cnt - 1'b1;
          ready_n = (cnt == CW'(1));
        end
      end
    endcase
    // A new frame can start from IDLE or directly off the final READY cycle of the previous one.
    if (start) begin
      state_n = ST_SYNC;
      cnt_n   = CW'(SYNC_W - 1);
      sh_n    = {SYNC, DIN} << 1;
      dout_n  = SYNC[SYNC_W-1];
      dvld_n  = 1'b1;
      fdone_n = 1'b0;
      ready_n = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sh         <= '0;
      D_OUT      <= 1'b0;
      D_VLD      <= 1'b0;
      FRAME_DONE <= 1'b0;
      READY      <= 1'b1;
      BUSY       <= 1'b0;
      FRAME_CNT  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sh         <= sh_n;
      D_OUT      <= dout_n;
      D_VLD      <= dvld_n;
      FRAME_DONE <= fdone_n;
      READY      <= ready_n;
      BUSY       <= (state_n != ST_IDLE);
      FRAME_CNT  <= fcnt_n;
    end
  end

endmodule
